// File: rtl/snowbro2_tile_fetch.sv
// snowbro2_tile_fetch: queues tile-row requests, reads one 32-bit GFX word per row and serialises 8 4bpp pixels.
module snowbro2_tile_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W = 16,
  parameter logic [21:0] BASE = 22'h0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [CODE_W-1:0] REQ_CODE,
  input  logic [2:0]        REQ_ROW,
  input  logic              REQ_FLIPX,
  input  logic [7:0]        REQ_TAG,
  output logic              GFX_CS,
  output logic [21:0]       GFX_ADDR,
  input  logic              GFX_OK,
  input  logic [31:0]       GFX_DOUT,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic [3:0]        PIX_DATA,
  output logic [7:0]        PIX_TAG,
  output logic              PIX_LAST,
  output logic              BUSY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CODE_W + 12;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SHIFT} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count, count_n;
  logic push, pop, done, latch, flip;
  logic [31:0] sh, sel;
  logic [2:0] idx;
  logic [7:0] tag;
  assign head = mem[rp];
  assign push = REQ_VALID && REQ_READY;
  assign done = state == SHIFT && PIX_READY && idx == 3'd7;
  assign pop = (state == IDLE || done) && count != '0;
  assign latch = state == WAIT && GFX_OK;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_n = pop ? ISSUE : state == ISSUE ? WAIT : latch ? SHIFT : done ? IDLE : state;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= {REQ_CODE, REQ_ROW, REQ_FLIPX, REQ_TAG};
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      REQ_READY <= 1'b1;
      GFX_CS <= 1'b0;
      GFX_ADDR <= '0;
      sh <= '0;
      idx <= '0;
      flip <= 1'b0;
      tag <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) begin
        rp <= rp + AW'(1);
        GFX_ADDR <= BASE + 22'({head[EW-1:12], head[11:9], 1'b0});
        GFX_CS <= 1'b1;
        flip <= head[8];
        tag <= head[7:0];
      end else if (latch) begin
        GFX_CS <= 1'b0;
        sh <= GFX_DOUT;
        idx <= '0;
      end
      if (PIX_VALID && PIX_READY) idx <= idx + 3'd1;
      count <= count_n;
      REQ_READY <= count_n != FULL;
    end
  end
  assign sel = flip ? sh >> {idx, 2'b00} : sh >> (5'd28 - {idx, 2'b00});
  assign PIX_VALID = state == SHIFT;
  assign PIX_DATA = sel[3:0];
  assign PIX_TAG = tag;
  assign PIX_LAST = PIX_VALID && idx == 3'd7;
  assign BUSY = count != '0 || state != IDLE;
endmodule

// File: tb/tb_snowbro2_tile_fetch.sv
// tb_snowbro2_tile_fetch: directed vector table plus full-FIFO and mid-fetch reset sequences.
module tb_snowbro2_tile_fetch;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic REQ_VALID = 1'b0;
  logic REQ_READY;
  logic [15:0] REQ_CODE = '0;
  logic [2:0] REQ_ROW = '0;
  logic REQ_FLIPX = 1'b0;
  logic [7:0] REQ_TAG = '0;
  logic GFX_CS;
  logic [21:0] GFX_ADDR;
  logic GFX_OK = 1'b0;
  logic [31:0] GFX_DOUT = '0;
  logic PIX_VALID;
  logic PIX_READY = 1'b1;
  logic [3:0] PIX_DATA;
  logic [7:0] PIX_TAG;
  logic PIX_LAST;
  logic BUSY;

  snowbro2_tile_fetch dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_CODE(REQ_CODE), .REQ_ROW(REQ_ROW), .REQ_FLIPX(REQ_FLIPX), .REQ_TAG(REQ_TAG),
    .GFX_CS(GFX_CS), .GFX_ADDR(GFX_ADDR), .GFX_OK(GFX_OK), .GFX_DOUT(GFX_DOUT),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA), .PIX_TAG(PIX_TAG),
    .PIX_LAST(PIX_LAST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] d;
    logic [7:0] t;
    logic l;
  } pix_t;

  typedef struct {
    logic [15:0] code;
    logic [2:0] row;
    logic flip;
    logic [7:0] tag;
    int lat;
    bit stale;
    bit bp;
    logic [31:0] dout;
    logic [21:0] addr;
    logic [31:0] pix;
  } vec_t;

  pix_t got[$];
  logic [21:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int hold_err = 0;
  int lat = 0;
  int cyc = 0;
  int rk = 0;
  bit stale_mode = 0;
  bit use_rom = 0;
  bit bp_mode = 0;
  logic [31:0] cur_dout = '0;
  bit hold_pend = 0;
  logic [12:0] held;
  vec_t vt[6];

  function automatic logic [31:0] rom(input logic [21:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  function automatic logic [31:0] pixword(input logic [31:0] d, input logic f);
    logic [31:0] r;
    r = d;
    if (f) for (int i = 0; i < 8; i++) r[31-4*i -: 4] = d[4*i +: 4];
    return r;
  endfunction

  function automatic logic [31:0] dout_of(input logic [21:0] a);
    return use_rom ? rom(a) : cur_dout;
  endfunction

  // Slot model: OK after lat cycles of CS, or (stale mode) OK always high with stale data until the second CS cycle.
  always @(posedge CLK) begin
    #1;
    if (GFX_CS) begin
      if (cyc == 0) addr_q.push_back(GFX_ADDR);
      cyc++;
    end else cyc = 0;
    if (stale_mode) begin
      GFX_OK = 1'b1;
      GFX_DOUT = (GFX_CS && cyc >= 2) ? dout_of(GFX_ADDR) : 32'hDEADBEEF;
    end else begin
      GFX_OK = GFX_CS && cyc > lat;
      GFX_DOUT = GFX_OK ? dout_of(GFX_ADDR) : 32'h0BAD0BAD;
    end
  end

  always @(posedge CLK) begin
    #1;
    if (!bp_mode) rk = 0;
    PIX_READY = bp_mode ? (rk % 4 == 0 || rk % 4 == 3) : 1'b1;
    rk++;
  end

  always @(negedge CLK) begin
    if (RESET) hold_pend = 0;
    else begin
      if (hold_pend && PIX_VALID && {PIX_DATA, PIX_TAG, PIX_LAST} !== held) hold_err++;
      if (hold_pend && !PIX_VALID) hold_err++;
      hold_pend = PIX_VALID && !PIX_READY;
      held = {PIX_DATA, PIX_TAG, PIX_LAST};
      if (PIX_VALID && PIX_READY) got.push_back('{PIX_DATA, PIX_TAG, PIX_LAST});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [15:0] code, input logic [2:0] row, input logic f, input logic [7:0] tag);
    @(posedge CLK); #1;
    for (int c = 0; c < 100 && !REQ_READY; c++) begin
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b1;
    REQ_CODE = code;
    REQ_ROW = row;
    REQ_FLIPX = f;
    REQ_TAG = tag;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int limit);
    for (int c = 0; c < limit && got.size() < n; c++) @(posedge CLK);
  endtask

  function automatic logic [31:0] row_word(input int base);
    logic [31:0] w = '0;
    for (int k = 0; k < 8; k++) w = {w[27:0], (base + k < got.size()) ? got[base+k].d : 4'hX};
    return w;
  endfunction

  task automatic run_vec(input int n);
    logic [7:0] lm;
    logic tag_ok;
    vec_t v;
    v = vt[n];
    got.delete();
    addr_q.delete();
    lat = v.lat;
    stale_mode = v.stale;
    bp_mode = v.bp;
    cur_dout = v.dout;
    use_rom = 0;
    push_one(v.code, v.row, v.flip, v.tag);
    wait_pix(8, 300);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    lm = '0;
    tag_ok = 1'b1;
    for (int k = 0; k < got.size() && k < 8; k++) begin
      lm[k] = got[k].l;
      if (got[k].t !== v.tag) tag_ok = 1'b0;
    end
    chk($sformatf("vec%0d addr", n), 64'(addr_q.size() > 0 ? addr_q[0] : 22'hX), 64'(v.addr));
    chk($sformatf("vec%0d count", n), 64'(got.size()), 64'd8);
    chk($sformatf("vec%0d pixels", n), 64'(row_word(0)), 64'(v.pix));
    chk($sformatf("vec%0d tag", n), 64'(tag_ok), 64'd1);
    chk($sformatf("vec%0d last", n), 64'(lm), 64'h80);
    chk($sformatf("vec%0d idle", n), 64'({BUSY, GFX_CS, PIX_VALID}), 64'd0);
    stale_mode = 0;
    bp_mode = 0;
  endtask

  initial begin
    logic [5:0] rdy;
    logic [15:0] code;
    vt[0] = '{16'h0012, 3'd3, 1'b0, 8'hA5, 5, 1'b0, 1'b0, 32'h01234567, 22'h000126, 32'h01234567};
    vt[1] = '{16'h0012, 3'd3, 1'b1, 8'hA5, 5, 1'b0, 1'b0, 32'h01234567, 22'h000126, 32'h76543210};
    vt[2] = '{16'h0012, 3'd3, 1'b0, 8'hA5, 0, 1'b1, 1'b0, 32'h01234567, 22'h000126, 32'h01234567};
    vt[3] = '{16'h00AB, 3'd7, 1'b0, 8'h3C, 2, 1'b0, 1'b1, 32'h89ABCDEF, 22'h000ABE, 32'h89ABCDEF};
    vt[4] = '{16'hFFFF, 3'd0, 1'b1, 8'hFF, 1, 1'b0, 1'b0, 32'hFEDCBA98, 22'h0FFFF0, 32'h89ABCDEF};
    vt[5] = '{16'h8001, 3'd5, 1'b0, 8'h00, 3, 1'b0, 1'b1, 32'hCAFEF00D, 22'h08001A, 32'hCAFEF00D};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset ready/cs/valid/last/busy", 64'({REQ_READY, GFX_CS, PIX_VALID, PIX_LAST, BUSY}), 64'b10000);
    chk("reset addr", 64'(GFX_ADDR), 64'd0);
    chk("reset data/tag", 64'({PIX_DATA, PIX_TAG}), 64'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    for (int n = 0; n < 6; n++) run_vec(n);
    chk("backpressure hold", 64'(hold_err), 64'd0);

    got.delete();
    addr_q.delete();
    use_rom = 1;
    lat = 20;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      REQ_VALID = 1'b1;
      REQ_CODE = 16'h0100 + 16'(k);
      REQ_ROW = 3'(k);
      REQ_FLIPX = k[0];
      REQ_TAG = 8'h10 + 8'(k);
      @(negedge CLK);
      rdy[k] = REQ_READY;
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("full ready pattern", 64'(rdy), 64'b011111);
    chk("full ready low", 64'({REQ_READY, BUSY}), 64'b01);
    wait_pix(40, 1000);
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    chk("full pixel count", 64'(got.size()), 64'd40);
    for (int k = 0; k < 5; k++) begin
      code = 16'h0100 + 16'(k);
      chk($sformatf("full row%0d addr", k), 64'(addr_q.size() > k ? addr_q[k] : 22'hX), 64'(22'({code, 3'(k), 1'b0})));
      chk($sformatf("full row%0d pixels", k), 64'(row_word(8*k)), 64'(pixword(rom(22'({code, 3'(k), 1'b0})), k[0])));
      chk($sformatf("full row%0d tag", k), 64'(got.size() > 8*k+7 ? got[8*k+7].t : 8'hX), 64'(8'h10 + 8'(k)));
    end
    chk("full drained", 64'({REQ_READY, BUSY}), 64'b10);

    got.delete();
    addr_q.delete();
    lat = 60;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      REQ_VALID = 1'b1;
      REQ_CODE = 16'h0200 + 16'(k);
      REQ_ROW = 3'd1;
      REQ_FLIPX = 1'b0;
      REQ_TAG = 8'h77;
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("pre-reset cs/busy", 64'({GFX_CS, BUSY, PIX_VALID}), 64'b110);
    @(posedge CLK); #3;
    RESET = 1'b1;
    #1;
    chk("async reset cs/valid/busy", 64'({GFX_CS, PIX_VALID, BUSY}), 64'd0);
    chk("async reset ready/addr", 64'({REQ_READY, GFX_ADDR}), 64'(23'h400000));
    @(posedge CLK); #1;
    RESET = 1'b0;
    got.delete();
    addr_q.delete();
    repeat (80) @(posedge CLK);
    @(negedge CLK);
    chk("post-reset no pixels", 64'(got.size()), 64'd0);
    chk("post-reset no fetch", 64'(addr_q.size()), 64'd0);
    chk("post-reset idle", 64'({BUSY, GFX_CS}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snowbro2_tile_fetch.md
Name: snowbro2_tile_fetch

Overview:
- Consumer stage on the GFX sprite slot (GFX_CS/GFX0_ADDR/GFX_OK/GFX0_DOUT) of the SDRAM bank-1 ROM arbiter.
- Accepts tile-row fetch requests from the GP9001 object engine into a small request FIFO.
- Issues one 32-bit SDRAM read per request and serialises the 8 4bpp pixels to the line-buffer writer, one pixel per cycle, with backpressure.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- CODE_W, 16, tile code width
- BASE, 22'h0, word offset added to the computed GFX address

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request offered
- REQ_READY  out  1  FIFO not full; request accepted when VALID&&READY
- REQ_CODE  in  CODE_W  tile code
- REQ_ROW  in  3  pixel row within 8x8 tile
- REQ_FLIPX  in  1  emit pixels in reverse order
- REQ_TAG  in  8  opaque tag (palette/x position) returned with pixels
- GFX_CS  out  1  slot read request
- GFX_ADDR  out  22  slot word address
- GFX_OK  in  1  slot data valid for current address
- GFX_DOUT  in  32  slot read data
- PIX_VALID  out  1  pixel available
- PIX_READY  in  1  downstream accepts pixel
- PIX_DATA  out  4  pixel colour index
- PIX_TAG  out  8  tag of the originating request
- PIX_LAST  out  1  high on the 8th pixel of a row
- BUSY  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async): FIFO empty, FSM=IDLE, GFX_CS=0, GFX_ADDR=0, PIX_VALID=0, PIX_DATA=0, PIX_TAG=0, PIX_LAST=0, REQ_READY=1, BUSY=0.
- FIFO:
  - Entries hold {code,row,flipx,tag}.
  - Write and read in the same cycle when full is allowed; count is unchanged.
  - REQ_READY = !full, registered from count.
  - A push while full is ignored and never corrupts the FIFO.
- Address: GFX_ADDR = BASE + {code, row, 1'b0}, truncated to 22 bits (wraps modulo 2^22). One row = 2 SDRAM words = 32 bits.
- FSM: IDLE -> ISSUE -> WAIT -> SHIFT -> IDLE.
  - IDLE: if FIFO non-empty, pop the head into the working regs, load GFX_ADDR, assert GFX_CS. Go to ISSUE.
  - ISSUE: one guard cycle. GFX_OK is ignored here because it may still reflect the previous address. Go to WAIT.
  - WAIT: GFX_CS held high with GFX_ADDR stable. On GFX_OK=1: latch GFX_DOUT into the shift register, drop GFX_CS the next cycle, clear pixel index to 0, go to SHIFT. No timeout.
  - SHIFT: PIX_VALID=1.
    - PIX_DATA = nibble selected by index i: flipx=0 gives bits [31-4i:28-4i]; flipx=1 gives bits [4i+3:4i].
    - PIX_TAG = working tag. PIX_LAST = (i==7).
    - On PIX_VALID&&PIX_READY, i increments.
    - On acceptance with i=7: if FIFO non-empty, go straight to the IDLE pop action (ISSUE next cycle, no bubble cycle in IDLE). Otherwise go to IDLE with PIX_VALID=0.
- PIX_* outputs are stable while PIX_VALID=1 and PIX_READY=0.
- Latency: pop to first pixel ≥ 3 cycles + SDRAM latency. Minimum per row = 3 + 8 cycles with GFX_OK immediate.
- GFX_DOUT is sampled only in WAIT when GFX_OK=1.
- Reset asserted mid-fetch: everything returns to reset values immediately. Queued requests and in-flight data are discarded, and GFX_CS drops asynchronously.

Test Plan:
- Fetch: one request code=16'h0012, row=3, flipx=0, tag=8'hA5. Slot returns OK 5 cycles after CS with DOUT=32'h01234567. Required: GFX_ADDR=22'h000126, CS high until OK, pixels 0,1,2,3,4,5,6,7 with tag A5 and LAST on pixel 7.
- Flip: same as the fetch test with flipx=1 -> pixels 7,6,5,4,3,2,1,0.
- Stale OK: GFX_OK held at 1 across request issue. Required: data not latched in ISSUE, latched on first WAIT cycle, correct pixels.
- Backpressure: PIX_READY toggled 1,0,0,1,... Required: PIX_DATA/TAG/LAST hold while not ready; exactly 8 pixels emitted, none lost or duplicated.
- Full FIFO: push 6 requests back-to-back with OK delayed 20 cycles. Required: REQ_READY drops after 4 accepted entries (plus the one popped), pushes while full are ignored, and all accepted rows are emitted in order. Push and pop in the same cycle when full leaves count unchanged.
- Reset mid-WAIT: RESET asserted while CS=1 with 2 queued entries. Required: CS=0 and PIX_VALID=0 immediately, BUSY=0. After release, no pixels are emitted without new requests.
